// File: rtl/dff_bank_arbiter_if.sv
// Requester-side bus of the shared DFF bank arbiter: write requests and data
// in, grant/ack handshake and bank contents out.
interface dff_bank_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic                  clr_req;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      q;
  logic [WIDTH-1:0]      qbar;
  logic                  busy;

  // Requesters (and the bench) drive requests, data and the clear command.
  modport master (
    output req, wdata, clr_req,
    input  gnt, ack, q, qbar, busy
  );

  // The arbiter owns the handshake outputs and the bank.
  modport slave (
    input  req, wdata, clr_req,
    output gnt, ack, q, qbar, busy
  );
endinterface

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter/sequencer sharing one WIDTH-bit negative-edge register
// bank between NREQ requesters. Each write takes IDLE -> GRANT -> WRITE, a
// synchronous clear takes IDLE -> CLEAR, and clr (active-low) resets
// everything asynchronously, discarding any in-flight transaction.
module dff_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              clr,
  dff_bank_arbiter_if.slave bus
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_WRITE,
    S_CLEAR
  } state_t;

  state_t            state_q,  state_d;
  logic [NREQ-1:0]   gnt_q,    gnt_d;
  logic [NREQ-1:0]   ack_q,    ack_d;
  logic [WIDTH-1:0]  bank_q,   bank_d;
  logic [IDXW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0]   winner_q, winner_d;

  logic              rr_found;
  logic [IDXW-1:0]   rr_idx;

  // (base + off) mod NREQ; NREQ need not be a power of two.
  function automatic logic [IDXW-1:0] wrap_add(input logic [IDXW-1:0] base,
                                               input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    return IDXW'(sum);
  endfunction

  // Round-robin pick: first active request scanning upward from rr_ptr.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    rr_found = 1'b0;
    rr_idx   = rr_ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!rr_found && bus.req[wrap_add(rr_ptr_q, k)]) begin
        rr_found = 1'b1;
        rr_idx   = wrap_add(rr_ptr_q, k);
      end
    end
  end

  // Next-state and next-output logic of the sequencer.
  always_comb begin
    state_d  = state_q;
    gnt_d    = '0;
    ack_d    = '0;
    bank_d   = bank_q;
    rr_ptr_d = rr_ptr_q;
    winner_d = winner_q;

    unique case (state_q)
      S_IDLE: begin
        // The clear command outranks every write request.
        if (bus.clr_req) begin
          state_d = S_CLEAR;
        end else if (rr_found) begin
          winner_d = rr_idx;
          gnt_d    = NREQ'(1) << rr_idx;
          state_d  = S_GRANT;
        end
      end
      S_GRANT: begin
        if (bus.req[winner_q]) begin
          bank_d   = bus.wdata[winner_q*WIDTH +: WIDTH];
          ack_d    = NREQ'(1) << winner_q;
          rr_ptr_d = wrap_add(winner_q, 1);
          state_d  = S_WRITE;
        end else begin
          // Requester withdrew: abort without advancing the pointer, so it
          // keeps its turn.
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        // Recovery cycle; clr_req is only honoured back in IDLE.
        state_d = S_IDLE;
      end
      S_CLEAR: begin
        bank_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, handshake and bank registers; all update on the falling edge.
  always_ff @(negedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      ack_q    <= '0;
      bank_q   <= '0;
      rr_ptr_q <= '0;
      winner_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      bank_q   <= bank_d;
      rr_ptr_q <= rr_ptr_d;
      winner_q <= winner_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.ack  = ack_q;
  assign bus.q    = bank_q;
  assign bus.qbar = ~bank_q;
  assign bus.busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter: grants and acked writes are predicted
// into queues when stimulus is driven and retired as the DUT produces them.
module tb_dff_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  typedef struct packed {
    logic [NREQ-1:0]  who;
    logic [WIDTH-1:0] data;
  } ack_item_t;

  logic clk;
  logic clr;

  dff_bank_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  logic [NREQ-1:0] gnt_exp[$];
  ack_item_t       ack_exp[$];
  logic [NREQ-1:0] prev_gnt;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int i, input logic [WIDTH-1:0] v);
    bus.wdata[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic expect_write(input logic [NREQ-1:0] who,
                              input logic [WIDTH-1:0] data);
    ack_item_t it;
    it.who  = who;
    it.data = data;
    gnt_exp.push_back(who);
    ack_exp.push_back(it);
  endtask

  // Advance to the next rising edge (DUT is quiet there) and run the
  // invariant checks plus the grant/ack scoreboards.
  task automatic step();
    logic [WIDTH-1:0] inv;
    logic [NREQ-1:0]  g;
    ack_item_t        it;
    @(posedge clk);
    inv = ~bus.q;
    check("qbar_is_not_q", bus.qbar, inv);
    check("gnt_onehot0", 64'($onehot0(bus.gnt)), 64'd1);
    check("ack_onehot0", 64'($onehot0(bus.ack)), 64'd1);
    check("gnt_ack_exclusive", 64'((|bus.gnt) & (|bus.ack)), 64'd0);
    if (bus.gnt != '0) begin
      if (gnt_exp.size() == 0) begin
        check("gnt_unexpected", bus.gnt, 0);
      end else begin
        g = gnt_exp.pop_front();
        check("gnt_order", bus.gnt, g);
      end
    end
    if (bus.ack != '0) begin
      check("ack_follows_gnt", bus.ack, prev_gnt);
      if (ack_exp.size() == 0) begin
        check("ack_unexpected", bus.ack, 0);
      end else begin
        it = ack_exp.pop_front();
        check("ack_who", bus.ack, it.who);
        check("q_on_ack", bus.q, it.data);
      end
    end
    prev_gnt = bus.gnt;
  endtask

  initial begin
    prev_gnt    = '0;
    clr         = 1'b0;
    bus.req     = 4'b1111;
    bus.clr_req = 1'b1;
    bus.wdata   = '0;

    // 1. Reset holds everything idle regardless of requests.
    repeat (3) @(posedge clk);
    check("rst_q", bus.q, 8'h00);
    check("rst_qbar", bus.qbar, 8'hFF);
    check("rst_gnt", bus.gnt, 0);
    check("rst_ack", bus.ack, 0);
    check("rst_busy", bus.busy, 0);

    clr         = 1'b1;
    bus.clr_req = 1'b0;
    bus.req     = 4'b0001;
    set_data(0, 8'hA5);
    expect_write(4'b0001, 8'hA5);
    step();
    check("t1_busy_in_grant", bus.busy, 1);
    step();
    check("t1_qbar", bus.qbar, 8'h5A);
    bus.req = '0;
    step();
    check("t1_busy_done", bus.busy, 0);
    check("t1_ack_done", bus.ack, 0);

    // 2. Round robin from rr_ptr=0 (fresh reset between edges).
    #2 clr = 1'b0;
    #1 clr = 1'b1;
    check("t2_q_after_reset", bus.q, 8'h00);
    set_data(0, 8'h11);
    set_data(1, 8'h22);
    set_data(2, 8'h33);
    set_data(3, 8'h44);
    bus.req = 4'b1111;
    expect_write(4'b0001, 8'h11);
    expect_write(4'b0010, 8'h22);
    expect_write(4'b0100, 8'h33);
    expect_write(4'b1000, 8'h44);
    expect_write(4'b0001, 8'h11);
    repeat (14) step();
    bus.req = '0;
    repeat (2) step();
    check("t2_all_acked", ack_exp.size(), 0);

    // 3. Clear wins over a simultaneous request (rr_ptr=1 now).
    set_data(1, 8'h3C);
    bus.req = 4'b0010;
    expect_write(4'b0010, 8'h3C);
    step();
    step();
    bus.req = '0;
    step();
    check("t3_q_before", bus.q, 8'h3C);
    bus.clr_req = 1'b1;
    bus.req     = 4'b0100;
    set_data(2, 8'h77);
    expect_write(4'b0100, 8'h77);
    step();
    check("t3_busy_clear", bus.busy, 1);
    check("t3_no_gnt_in_clear", bus.gnt, 0);
    bus.clr_req = 1'b0;
    step();
    check("t3_q_cleared", bus.q, 8'h00);
    check("t3_qbar_cleared", bus.qbar, 8'hFF);
    step();
    step();
    bus.req = '0;
    step();

    // 4. Abort keeps requester 1's turn (move rr_ptr to 1 first).
    set_data(0, 8'h5E);
    bus.req = 4'b0001;
    expect_write(4'b0001, 8'h5E);
    step();
    step();
    bus.req = '0;
    step();
    set_data(1, 8'h99);
    bus.req = 4'b0010;
    gnt_exp.push_back(4'b0010);
    step();
    bus.req = '0;
    step();
    check("t4_no_ack", bus.ack, 0);
    check("t4_gnt_dropped", bus.gnt, 0);
    check("t4_idle", bus.busy, 0);
    check("t4_q_kept", bus.q, 8'h5E);
    bus.req = 4'b1111;
    expect_write(4'b0010, 8'h99);
    step();
    step();
    bus.req = '0;
    step();

    // 5. Asynchronous clear while in GRANT.
    set_data(2, 8'hA7);
    bus.req = 4'b0100;
    gnt_exp.push_back(4'b0100);
    step();
    #2 clr = 1'b0;
    #1;
    check("t5_q_async", bus.q, 8'h00);
    check("t5_qbar_async", bus.qbar, 8'hFF);
    check("t5_gnt_async", bus.gnt, 0);
    check("t5_busy_async", bus.busy, 0);
    bus.req = '0;
    step();
    clr = 1'b1;
    step();
    step();
    check("t5_q_stays", bus.q, 8'h00);

    // 6. Clear raised during WRITE waits for the write to finish.
    set_data(0, 8'hC3);
    bus.req = 4'b0001;
    expect_write(4'b0001, 8'hC3);
    step();
    step();
    bus.clr_req = 1'b1;
    bus.req     = '0;
    step();
    check("t6_q_written", bus.q, 8'hC3);
    check("t6_idle_after_write", bus.busy, 0);
    step();
    check("t6_busy_clear", bus.busy, 1);
    check("t6_q_before_clear", bus.q, 8'hC3);
    bus.clr_req = 1'b0;
    step();
    check("t6_q_cleared", bus.q, 8'h00);
    check("t6_qbar_cleared", bus.qbar, 8'hFF);
    check("t6_idle", bus.busy, 0);

    check("gnt_queue_drained", gnt_exp.size(), 0);
    check("ack_queue_drained", ack_exp.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
